fpu_mult_host: RTL and testbench

Initiator/collector for the FPU multiplier's STB/BUSY handshake. It accepts operand pairs from a host, issues them to `multiplier` through `mult_input_STB`/`mult_BUSY`, and consumes products through `mult_output_STB`/`output_module_BUSY`. Products are returned to the host in issue order. It sits between the control/test logic and the multiplier, and replaces the hand-driven stimulus used so far.

---
 rtl/fpu_hs_pkg.sv | 13 +
 rtl/hs_fifo.sv | 53 +++++
 rtl/fpu_mult_host.sv | 98 +++++++++
 tb/tb_fpu_mult_host.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_hs_pkg.sv
// Shared types and defaults for the FPU multiplier host handshake block.
package fpu_hs_pkg;

   localparam int FP_WIDTH = 32;

   typedef logic [FP_WIDTH-1:0] fp32_t;

   typedef struct packed {
      fp32_t a;
      fp32_t b;
   } operand_pair_t;

endpackage

// File: rtl/hs_fifo.sv
// Synchronous FIFO with registered storage; full/empty come from an extra pointer wrap bit.
module hs_fifo #(
   parameter int W = 32,
   parameter int D = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(D+1)-1:0] count
);

   localparam int AW = $clog2(D);
   localparam int CW = $clog2(D+1);

   logic [W-1:0]  mem [D];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A push is refused while full even if a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = CW'(wr_ptr - rd_ptr);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < D; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/fpu_mult_host.sv
// Host-side initiator/collector for the FPU multiplier STB/BUSY handshake.
// Operands are queued, issued against a credit limit, and products returned in order.
module fpu_mult_host
   import fpu_hs_pkg::*;
#(
   parameter int WIDTH = FP_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic                       in_STB,
   output logic                       in_BUSY,
   output logic [WIDTH-1:0]           input_a,
   output logic [WIDTH-1:0]           input_b,
   output logic                       mult_input_STB,
   input  logic                       mult_BUSY,
   input  logic [WIDTH-1:0]           output_mult,
   input  logic                       mult_output_STB,
   output logic                       output_module_BUSY,
   output logic [WIDTH-1:0]           result,
   output logic                       result_STB,
   input  logic                       result_BUSY,
   output logic [$clog2(DEPTH+1)-1:0] in_flight,
   output logic                       idle,
   output logic                       err_unexpected
);

   localparam int CW = $clog2(DEPTH+1);

   logic [2*WIDTH-1:0] op_head;
   logic               op_full;
   logic               op_empty;
   logic [CW-1:0]      op_count;
   logic               res_full;
   logic               res_empty;
   logic [CW-1:0]      res_count;
   logic [CW:0]        credit_used;
   logic               issue;
   logic               collect;
   logic               unused_fifo_status;

   hs_fifo #(.W(2*WIDTH), .D(DEPTH)) u_op_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_STB),
      .push_data ({in_a, in_b}),
      .pop       (issue),
      .head      (op_head),
      .full      (op_full),
      .empty     (op_empty),
      .count     (op_count)
   );

   hs_fifo #(.W(WIDTH), .D(DEPTH)) u_res_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (collect),
      .push_data (output_mult),
      .pop       (result_STB && !result_BUSY),
      .head      (result),
      .full      (res_full),
      .empty     (res_empty),
      .count     (res_count)
   );

   // Result space is reserved at issue time, so the result FIFO can never be full on collect.
   assign unused_fifo_status = ^{op_count, res_full};

   assign {input_a, input_b} = op_head;
   assign in_BUSY            = op_full;
   assign credit_used        = {1'b0, in_flight} + {1'b0, res_count};
   assign mult_input_STB     = !op_empty && (credit_used < (CW+1)'(DEPTH));
   assign issue              = mult_input_STB && !mult_BUSY;
   assign output_module_BUSY = 1'b0;
   assign collect            = mult_output_STB && (in_flight != '0);
   assign result_STB         = !res_empty;
   assign idle               = op_empty && res_empty && (in_flight == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         in_flight      <= '0;
         err_unexpected <= 1'b0;
      end else begin
         if (issue && !collect) begin
            in_flight <= in_flight + CW'(1);
         end else if (collect && !issue) begin
            in_flight <= in_flight - CW'(1);
         end
         // Products with nothing outstanding are swallowed and flagged.
         if (mult_output_STB && (in_flight == '0)) begin
            err_unexpected <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fpu_mult_host.sv
// Directed bench for fpu_mult_host with a behavioural multiplier and an in-order result scoreboard.
module tb_fpu_mult_host;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);
   localparam logic [31:0] ONE = 32'h3F800000;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_STB;
   logic             in_BUSY;
   logic [WIDTH-1:0] input_a;
   logic [WIDTH-1:0] input_b;
   logic             mult_input_STB;
   logic             mult_BUSY = 1'b0;
   logic [WIDTH-1:0] output_mult;
   logic             mult_output_STB;
   logic             output_module_BUSY;
   logic [WIDTH-1:0] result;
   logic             result_STB;
   logic             result_BUSY;
   logic [CW-1:0]    in_flight;
   logic             idle;
   logic             err_unexpected;

   typedef struct {
      logic [31:0] p;
      int          rdy;
   } prod_t;

   prod_t       pq[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_e;
   int          n_assert   = 0;
   int          n_fail     = 0;
   int          cyc        = 0;
   int          issue_cnt  = 0;
   int          result_cnt = 0;
   logic        busy_hold  = 1'b0;
   logic        rand_stall = 1'b0;
   logic        out_hold   = 1'b0;
   logic        inj        = 1'b0;
   logic        mdl_stb    = 1'b0;
   logic [31:0] mdl_data   = 32'h0;

   assign mult_output_STB = inj | mdl_stb;
   assign output_mult     = inj ? ONE : mdl_data;

   fpu_mult_host #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_a               (in_a),
      .in_b               (in_b),
      .in_STB             (in_STB),
      .in_BUSY            (in_BUSY),
      .input_a            (input_a),
      .input_b            (input_b),
      .mult_input_STB     (mult_input_STB),
      .mult_BUSY          (mult_BUSY),
      .output_mult        (output_mult),
      .mult_output_STB    (mult_output_STB),
      .output_module_BUSY (output_module_BUSY),
      .result             (result),
      .result_STB         (result_STB),
      .result_BUSY        (result_BUSY),
      .in_flight          (in_flight),
      .idle               (idle),
      .err_unexpected     (err_unexpected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truncating fp32 multiply for normal operands; exact for the values used here.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      logic [9:0]  e;
      logic [22:0] f;
      m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      if (m[47]) begin
         e = e + 10'd1;
         f = m[46:24];
      end else begin
         f = m[45:23];
      end
      return {a[31] ^ b[31], e[7:0], f};
   endfunction

   // Multiplier model: fixed latency, drives its outputs 2 time units after the edge.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         pq.delete();
      end else begin
         if (mult_input_STB && !mult_BUSY) begin
            pq.push_back('{fp_mul(input_a, input_b), cyc + 2});
            issue_cnt++;
         end
         if (mdl_stb && !inj && !output_module_BUSY) begin
            pq.delete(0);
         end
      end
      #2;
      mdl_stb   = !out_hold && (pq.size() > 0) && (pq[0].rdy <= cyc);
      mdl_data  = mdl_stb ? pq[0].p : 32'h0;
      mult_BUSY = busy_hold | (rand_stall & ($urandom_range(0, 1) == 1));
   end

   always @(posedge clk) begin
      if (!rst && result_STB && !result_BUSY) begin
         result_cnt++;
         n_assert++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL result_extra observed=%h expected=none", result);
         end else begin
            exp_e = exp_q.pop_front();
            assert (result === exp_e)
               else begin
                  n_fail++;
                  $error("FAIL result_order observed=%h expected=%h", result, exp_e);
               end
         end
      end
   end

   logic        pw = 1'b0;
   logic [31:0] pa;
   logic [31:0] pb;
   always @(posedge clk) begin
      if (!rst && pw) begin
         n_assert++;
         assert (mult_input_STB === 1'b1 && input_a === pa && input_b === pb)
            else begin
               n_fail++;
               $error("FAIL stb_stable observed=%b/%h/%h expected=1/%h/%h",
                      mult_input_STB, input_a, input_b, pa, pb);
            end
      end
      pw = !rst && mult_input_STB && mult_BUSY;
      pa = input_a;
      pb = input_b;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      int t;
      t      = 0;
      in_a   = a;
      in_b   = b;
      in_STB = 1'b1;
      while (in_BUSY && t < 100) begin
         step();
         t++;
      end
      chk("push_accept", {31'b0, in_BUSY}, 32'h0);
      exp_q.push_back(e);
      step();
      in_STB = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int t;
      t = 0;
      while (!(idle && exp_q.size() == 0) && t < bound) begin
         step();
         t++;
      end
      chk("wait_idle", {31'b0, idle && (exp_q.size() == 0)}, 32'h1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_BUSY"},  {31'b0, in_BUSY},            32'h0);
      chk({tag, "_mstb"},     {31'b0, mult_input_STB},     32'h0);
      chk({tag, "_omBUSY"},   {31'b0, output_module_BUSY}, 32'h0);
      chk({tag, "_rstb"},     {31'b0, result_STB},         32'h0);
      chk({tag, "_inflight"}, 32'(in_flight),              32'h0);
      chk({tag, "_idle"},     {31'b0, idle},               32'h1);
      chk({tag, "_err"},      {31'b0, err_unexpected},     32'h0);
      chk({tag, "_result"},   result,                      32'h0);
      chk({tag, "_input_a"},  input_a,                     32'h0);
      chk({tag, "_input_b"},  input_b,                     32'h0);
   endtask

   initial begin
      int base_issue;
      int base_res;
      logic [31:0] bv;

      rst         = 1'b1;
      in_a        = '0;
      in_b        = '0;
      in_STB      = 1'b0;
      result_BUSY = 1'b0;
      step();
      step();
      chk_reset_vals("reset");
      rst = 1'b0;
      step();

      // Single op: 2.0 * 3.0
      push(32'h40000000, 32'h40400000, 32'h40C00000);
      chk("single_mstb", {31'b0, mult_input_STB}, 32'h1);
      chk("single_a", input_a, 32'h40000000);
      step();
      chk("single_inflight", 32'(in_flight), 32'h1);
      wait_idle(50);

      // Back-to-back pushes while the multiplier is stalled
      busy_hold = 1'b1;
      step();
      push(32'h40000000, 32'h40400000, 32'h40C00000);
      push(32'h40800000, 32'h40A00000, 32'h41A00000);
      step();
      chk("b2b_inflight", 32'(in_flight), 32'h0);
      chk("b2b_mstb", {31'b0, mult_input_STB}, 32'h1);
      chk("b2b_head_a", input_a, 32'h40000000);
      busy_hold = 1'b0;
      wait_idle(50);

      // Credit limit with the host refusing results
      result_BUSY = 1'b1;
      base_issue  = issue_cnt;
      base_res    = result_cnt;
      for (int i = 0; i < DEPTH + 2; i++) begin
         bv = 32'h40000000 | (32'(i) << 16);
         push(ONE, bv, bv);
      end
      repeat (8) step();
      chk("credit_issued", 32'(issue_cnt - base_issue), 32'(DEPTH));
      chk("credit_mstb", {31'b0, mult_input_STB}, 32'h0);
      chk("credit_inBUSY_lo", {31'b0, in_BUSY}, 32'h0);
      chk("credit_inflight", 32'(in_flight), 32'h0);
      for (int i = DEPTH + 2; i < 2 * DEPTH; i++) begin
         bv = 32'h40000000 | (32'(i) << 16);
         push(ONE, bv, bv);
      end
      chk("credit_inBUSY_hi", {31'b0, in_BUSY}, 32'h1);
      chk("credit_rstb", {31'b0, result_STB}, 32'h1);
      result_BUSY = 1'b0;
      wait_idle(200);
      chk("credit_drained", 32'(result_cnt - base_res), 32'(2 * DEPTH));

      // Random multiplier stalls; stability checked on every stalled edge
      rand_stall = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bv = 32'h40000000 | ($urandom & 32'h007FFFFF);
         push(ONE, bv, bv);
      end
      rand_stall = 1'b0;
      wait_idle(300);

      // Reset with two queued and one in flight
      out_hold = 1'b1;
      push(ONE, 32'h40000000, 32'h40000000);
      step();
      chk("mid_inflight1", 32'(in_flight), 32'h1);
      busy_hold = 1'b1;
      push(ONE, 32'h40400000, 32'h40400000);
      push(ONE, 32'h40800000, 32'h40800000);
      step();
      chk("mid_inflight2", 32'(in_flight), 32'h1);
      chk("mid_idle", {31'b0, idle}, 32'h0);
      rst = 1'b1;
      step();
      chk_reset_vals("midrst");
      rst = 1'b0;
      exp_q.delete();
      busy_hold = 1'b0;
      out_hold  = 1'b0;
      repeat (5) step();
      chk("post_rst_idle", {31'b0, idle}, 32'h1);
      chk("post_rst_err", {31'b0, err_unexpected}, 32'h0);

      // Unexpected product with nothing outstanding
      base_res = result_cnt;
      inj = 1'b1;
      step();
      inj = 1'b0;
      chk("unexp_err", {31'b0, err_unexpected}, 32'h1);
      chk("unexp_rstb", {31'b0, result_STB}, 32'h0);
      chk("unexp_inflight", 32'(in_flight), 32'h0);
      repeat (4) step();
      chk("unexp_sticky", {31'b0, err_unexpected}, 32'h1);
      chk("unexp_noresult", 32'(result_cnt - base_res), 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("unexp_cleared", {31'b0, err_unexpected}, 32'h0);

      // Operation still correct after the error episode
      push(32'h40800000, 32'h40A00000, 32'h41A00000);
      wait_idle(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
